// File: rtl/reaction_stats.sv
// reaction_stats: collects per-trial statistics from the reaction timer and
// converts the selected statistic into packed BCD for the seven-segment driver.
// Optional macro STATS_WORST_EN adds a worst-time register shown on sel = 3.
module reaction_stats #(
   parameter int DEPTH  = 4,
   parameter int MAX_MS = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        result_valid,
   input  logic [10:0] result_ms,
   input  logic        result_early,
   input  logic [1:0]  sel,
   output logic [15:0] bcd_out,
   output logic        stats_valid,
   output logic        busy,
   output logic [10:0] best_ms,
   output logic [10:0] avg_ms,
   output logic        avg_ok,
   output logic [7:0]  attempts,
   output logic [7:0]  early_cnt,
   output logic        drop_err
);
   localparam int          L     = $clog2(DEPTH);
   localparam int          SW    = 11 + L;
   localparam logic [10:0] MAX_V = 11'(MAX_MS);
   localparam logic [10:0] NONE  = 11'd2047;
   localparam logic [L:0]  FULL  = (L+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, UPDATE, CONV, DONE} state_t;

   state_t        state_q;
   logic [10:0]   cur_ms_q, pend_ms_q, last_q, best_q, avg_q;
   logic          cur_early_q, pend_early_q, pend_full_q;
   logic          avg_ok_q, drop_q, sv_q;
   logic [SW-1:0] sum_q;
   logic [L:0]    fill_q;
   logic [L-1:0]  wr_ptr_q;
   logic [10:0]   ring_q [DEPTH];
   logic [7:0]    attempts_q, early_q;
   logic [1:0]    sel_q;
   logic [3:0]    cnt_q;
   logic [26:0]   dd_q;
   logic [15:0]   bcd_q;
`ifdef STATS_WORST_EN
   logic [10:0]   worst_q;
`endif

   logic [10:0]   in_ms_d, evict_d, avg_d, conv_val_d;
   logic [SW-1:0] sum_d;
   logic [L:0]    fill_d;
   logic          exists_d;
   logic [26:0]   dd_src_d, dd_adj_d, dd_d;

   // Clamp the incoming time and compute the window update for the trial in flight
   always_comb begin
      in_ms_d = (result_ms > MAX_V) ? MAX_V : result_ms;
      evict_d = (fill_q == FULL) ? ring_q[wr_ptr_q] : 11'd0;
      sum_d   = sum_q + SW'(cur_ms_q) - SW'(evict_d);
      fill_d  = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
      avg_d   = (fill_d == FULL) ? 11'(sum_d >> L) : 11'd0;
   end

   // Pick the statistic to display and decide whether it exists yet
   always_comb begin
      conv_val_d = last_q;
      exists_d   = (best_q != NONE);
      case (sel)
         2'd0: if (attempts_q == 8'd0) exists_d = 1'b0;
         2'd1: conv_val_d = best_q;
         2'd2: begin
            conv_val_d = avg_q;
            if (!avg_ok_q) exists_d = 1'b0;
         end
         default: begin
`ifdef STATS_WORST_EN
            conv_val_d = worst_q;
`else
            exists_d = 1'b0;
`endif
         end
      endcase
   end

   // Double-dabble step: add 3 to every BCD nibble >= 5, then shift left by one
   assign dd_src_d        = (cnt_q == 4'd0) ? {16'h0000, conv_val_d} : dd_q;
   assign dd_adj_d[10:0]  = dd_src_d[10:0];
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_add3
         assign dd_adj_d[11+4*gi +: 4] = (dd_src_d[11+4*gi +: 4] >= 4'd5) ?
                                         dd_src_d[11+4*gi +: 4] + 4'd3 :
                                         dd_src_d[11+4*gi +: 4];
      end
   endgenerate
   assign dd_d = dd_adj_d << 1;

   // Main FSM: capture, statistics update, BCD conversion and result presentation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE; cur_ms_q <= '0; cur_early_q <= 1'b0;
         pend_ms_q <= '0; pend_early_q <= 1'b0; pend_full_q <= 1'b0;
         last_q <= '0; best_q <= NONE; avg_q <= '0; avg_ok_q <= 1'b0;
         sum_q <= '0; fill_q <= '0; wr_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
         attempts_q <= '0; early_q <= '0; drop_q <= 1'b0; sv_q <= 1'b0;
         sel_q <= '0; cnt_q <= '0; dd_q <= '0; bcd_q <= 16'hFFFF;
`ifdef STATS_WORST_EN
         worst_q <= '0;
`endif
      end else if (clr) begin
         state_q <= IDLE; cur_ms_q <= '0; cur_early_q <= 1'b0;
         pend_ms_q <= '0; pend_early_q <= 1'b0; pend_full_q <= 1'b0;
         last_q <= '0; best_q <= NONE; avg_q <= '0; avg_ok_q <= 1'b0;
         sum_q <= '0; fill_q <= '0; wr_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
         attempts_q <= '0; early_q <= '0; drop_q <= 1'b0; sv_q <= 1'b0;
         sel_q <= '0; cnt_q <= '0; dd_q <= '0; bcd_q <= 16'hFFFF;
`ifdef STATS_WORST_EN
         worst_q <= '0;
`endif
      end else begin
         sv_q <= 1'b0;
         // Results arriving while busy go to the single pending slot or are lost
         if (state_q != IDLE && result_valid) begin
            if (!pend_full_q) begin
               pend_ms_q <= in_ms_d; pend_early_q <= result_early; pend_full_q <= 1'b1;
            end else begin
               drop_q <= 1'b1;
            end
         end
         case (state_q)
            IDLE: begin
               if (pend_full_q) begin
                  cur_ms_q <= pend_ms_q; cur_early_q <= pend_early_q;
                  if (result_valid) begin
                     pend_ms_q <= in_ms_d; pend_early_q <= result_early;
                  end else begin
                     pend_full_q <= 1'b0;
                  end
                  state_q <= UPDATE;
               end else if (result_valid) begin
                  cur_ms_q <= in_ms_d; cur_early_q <= result_early;
                  state_q <= UPDATE;
               end else if (sel != sel_q) begin
                  cnt_q <= '0; state_q <= CONV;
               end
            end
            UPDATE: begin
               if (cur_early_q) begin
                  if (early_q != 8'hFF) early_q <= early_q + 8'd1;
               end else begin
                  last_q <= cur_ms_q;
                  if (cur_ms_q < best_q) best_q <= cur_ms_q;
`ifdef STATS_WORST_EN
                  if (cur_ms_q > worst_q) worst_q <= cur_ms_q;
`endif
                  if (attempts_q != 8'hFF) attempts_q <= attempts_q + 8'd1;
                  ring_q[wr_ptr_q] <= cur_ms_q;
                  sum_q    <= sum_d;
                  wr_ptr_q <= wr_ptr_q + 1'b1;
                  fill_q   <= fill_d;
                  avg_q    <= avg_d;
                  avg_ok_q <= (fill_d == FULL);
               end
               cnt_q <= '0; state_q <= CONV;
            end
            CONV: begin
               if (cnt_q == 4'd0) sel_q <= sel;
               if (cnt_q == 4'd0 && !exists_d) begin
                  bcd_q <= 16'hFFFF; sv_q <= 1'b1; state_q <= DONE;
               end else begin
                  dd_q  <= dd_d;
                  cnt_q <= cnt_q + 4'd1;
                  if (cnt_q == 4'd10) begin
                     bcd_q <= dd_d[26:11]; sv_q <= 1'b1; state_q <= DONE;
                  end
               end
            end
            DONE: state_q <= IDLE;
         endcase
      end
   end

   assign bcd_out     = bcd_q;
   assign stats_valid = sv_q;
   assign busy        = (state_q != IDLE);
   assign best_ms     = best_q;
   assign avg_ms      = avg_q;
   assign avg_ok      = avg_ok_q;
   assign attempts    = attempts_q;
   assign early_cnt   = early_q;
   assign drop_err    = drop_q;
endmodule

// File: doc/reaction_stats.md
Name: reaction_stats

Overview:
- Sits directly downstream of the reaction-timer FSM and consumes each finished trial: reaction time in ms plus an early-press flag.
- Keeps the following statistics:
  - last result;
  - best result;
  - rolling average over the last DEPTH trials;
  - attempt and early-press counters.
- Converts the statistic chosen by `sel` into 16-bit packed BCD `{d3,d2,d1,d0}`. The conversion is sequential (shift-add-3), and the output feeds the seven-segment driver.

Parameters:
- DEPTH, 4: rolling-average window. Must be a power of 2, from 2 to 16.
- MAX_MS, 1000: clamp ceiling for reaction times, which is also the timeout value.

Ports:
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear pulse (debounced clear button)
- result_valid  in  1  one-cycle pulse: a trial finished
- result_ms  in  11  reaction time in ms, sampled when result_valid is high
- result_early  in  1  trial was an early press, sampled with result_valid
- sel  in  2  display selection: 0 = last, 1 = best, 2 = average, 3 = worst (optional)
- bcd_out  out  16  packed BCD of the selected statistic; 16'hFFFF = blank
- stats_valid  out  1  one-cycle pulse when bcd_out updates
- busy  out  1  high in any state other than IDLE
- best_ms  out  11  best valid time; 2047 = none yet
- avg_ms  out  11  average of the last DEPTH valid times
- avg_ok  out  1  window holds DEPTH valid entries
- attempts  out  8  count of valid (non-early) trials, saturates at 255
- early_cnt  out  8  count of early trials, saturates at 255
- drop_err  out  1  sticky: a result was lost to overflow

Behaviour:
- Reset (rst_n low, asynchronous) sets the following values:
  - bcd_out = 16'hFFFF, best_ms = 2047, avg_ms = 0.
  - avg_ok, stats_valid, busy, drop_err = 0.
  - attempts = 0, early_cnt = 0.
  - Ring buffer, sum, fill count and pending register cleared; state = IDLE.
- clr high on a clock edge:
  - Same values as reset, applied synchronously from any state.
  - Aborts any conversion in progress.
  - clr wins over a simultaneous result_valid; that result is discarded.
- Input clamp: result_ms > MAX_MS is treated as MAX_MS.
- State machine IDLE -> UPDATE -> CONV -> DONE -> IDLE.
- IDLE:
  - If the pending register is full, or result_valid is high, capture the result and go to UPDATE. The pending register has priority.
  - Otherwise, if sel differs from sel_q (the sel value used for the last conversion), go to CONV.
- UPDATE (1 cycle), early trial:
  - early_cnt increments (saturating).
  - Buffer, last, best and average are unchanged.
- UPDATE (1 cycle), valid trial:
  - last_q <= value; best_ms <= min(best_ms, value); attempts increments (saturating).
  - Write value into the ring at wr_ptr. sum <= sum + value - evicted entry, where the evicted entry is 0 while the window is not yet full.
  - wr_ptr wraps modulo DEPTH; fill count saturates at DEPTH.
  - sum width = 11 + log2(DEPTH).
  - avg_ok goes high when the fill count reaches DEPTH.
  - avg_ms = sum >> log2(DEPTH), registered; it is 0 while avg_ok is low.
- CONV (exactly 11 cycles):
  - Latch sel into sel_q.
  - Run double-dabble on the selected 11-bit value: one shift per cycle, with add-3 on each nibble that is >= 5 before the shift.
  - If the selected statistic does not exist, skip the shifts and jump to DONE with blank (16'hFFFF). A statistic does not exist when:
    - best_ms = 2047 (no valid trial yet);
    - avg_ok is low and sel = 2;
    - no valid trial has occurred and sel = 0;
    - sel = 3 and STATS_WORST_EN is not defined.
- DONE (1 cycle): bcd_out <= result (d3 is 0 or 1, since values are at most 1000); stats_valid = 1.
- Latency: result_valid high at cycle k produces stats_valid high at cycle k+13.
- A sel-only reconversion takes 12 cycles, starting from the IDLE cycle that detects the change.
- result_valid while busy:
  - If the pending register is empty, store the result there; it is processed on the next return to IDLE.
  - If the pending register is already full, drop the result and set drop_err (sticky until clr or reset).
- A sel change during CONV does not disturb the running conversion. The mismatch is detected in IDLE and a reconversion follows.
- sel = 1 shows the best time; the average is floor division.

Optional Feature:
- Macro STATS_WORST_EN.
- Defined:
  - Adds a worst_q register: reset value 0, updated in UPDATE as max(worst_q, value) for valid trials.
  - sel = 3 converts worst_q, or shows blank if no valid trial has occurred.
- Undefined: no worst_q register exists, and sel = 3 always yields bcd_out = 16'hFFFF.
- Ports are identical in both builds.

Test Plan:
- Reset, then a valid trial of 287 ms with sel = 0:
  - stats_valid pulses 13 cycles after result_valid.
  - bcd_out = 16'h0287, attempts = 1, best_ms = 287.
- Trials of 300, 250, 400 and 1200 ms (clamped to 1000), then sel = 2:
  - avg_ok = 1, avg_ms = 487, bcd_out = 16'h0487.
  - A fifth trial of 100 ms evicts 300: avg_ms = 437.
- Early trial first, with sel = 1:
  - early_cnt = 1, attempts = 0, bcd_out = 16'hFFFF.
  - A following trial of 999 ms gives bcd_out = 16'h0999.
- Three result_valid pulses 2 cycles apart:
  - The first and second are processed in order, with two stats_valid pulses.
  - The third is dropped and drop_err = 1.
  - clr clears drop_err and all outputs back to their reset values.
- clr asserted mid-CONV on the same edge as result_valid:
  - State returns to IDLE, no stats_valid pulse, that result is discarded, bcd_out = 16'hFFFF.
- With STATS_WORST_EN, trials of 200 and 650 ms, sel = 3:
  - bcd_out = 16'h0650.
  - Without the macro: 16'hFFFF.
